gate_fault_frame_scheduler: RTL and testbench

//  Sequences one logic frame for a bank of fault-capable gates: clears gate state, then shares the

---
 rtl/gate_fault_frame_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_gate_fault_frame_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_fault_frame_scheduler.sv
// ---------------------------------------------------------------------------
// gate_fault_frame_scheduler
//
// Sequences one logic frame for a bank of fault-capable gates. A frame first
// pulses logic_reset to clear gate state. It then shares the single
// fault-trigger line between REQ_COUNT requesters in round-robin order, one
// grant per cycle. A frame ends after SETTLE_CYCLES quiet cycles. At most
// MAX_GRANTS fault pulses are issued per frame. Requests beyond that limit
// are dropped and flagged through the sticky overflow output.
//
// Ports
//   clk          in   1          clock, rising edge
//   reset        in   1          synchronous active-high, clears all state
//   frame_start  in   1          starts a frame when idle, ignored while busy
//   req          in   REQ_COUNT  level fault requests
//   logic_reset  out  1          one-cycle pulse in the CLEAR cycle
//   fault_pulse  out  1          one-cycle fault pulse, equals |grant
//   grant        out  REQ_COUNT  one-hot acknowledge of the served requester
//   busy         out  1          high from CLEAR through DONE
//   frame_done   out  1          one-cycle pulse in the DONE cycle
//   overflow     out  1          sticky, a request was dropped this frame
//
// All outputs come straight from flops. The state-decoded outputs are loaded
// from the next state, so they line up with the state register cycle for
// cycle.
// ---------------------------------------------------------------------------
module gate_fault_frame_scheduler #(
   parameter int REQ_COUNT     = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_GRANTS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic [REQ_COUNT-1:0] req,
   output logic                 logic_reset,
   output logic                 fault_pulse,
   output logic [REQ_COUNT-1:0] grant,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow
);

   localparam int PTR_W  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
   localparam int GCNT_W = $clog2(MAX_GRANTS + 1);
   localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [GCNT_W-1:0] MAX_G       = GCNT_W'(MAX_GRANTS);
   localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(REQ_COUNT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_EVAL   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [REQ_COUNT-1:0]   pending_q, pending_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
   logic [SCNT_W-1:0]      scnt_q, scnt_d;
   logic                   overflow_q, overflow_d;
   logic [REQ_COUNT-1:0]   grant_q, grant_d;
   logic                   fault_pulse_q, fault_pulse_d;
   logic                   logic_reset_q, logic_reset_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;

   logic [REQ_COUNT-1:0]   eff;
   logic [PTR_W-1:0]       winner;
   logic [REQ_COUNT-1:0]   winner_oh;
   logic                   grants_left;

   // First set bit of vec, scanning upward from start and wrapping at
   // REQ_COUNT. When vec is empty the result is unused by the caller.
   function automatic logic [PTR_W-1:0] rr_pick(
      input logic [REQ_COUNT-1:0] vec,
      input logic [PTR_W-1:0]     start
   );
      logic [PTR_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         idx = int'(start) + i;
         if (idx >= REQ_COUNT) begin
            idx = idx - REQ_COUNT;
         end
         if (!found && vec[idx[PTR_W-1:0]]) begin
            pick  = idx[PTR_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      // Live requests are merged with the ones still owed from earlier cycles.
      eff         = pending_q | req;
      winner      = rr_pick(eff, rr_ptr_q);
      winner_oh   = REQ_COUNT'(1) << winner;
      grants_left = (gcnt_q < MAX_G);

      state_d    = state_q;
      pending_d  = pending_q;
      rr_ptr_d   = rr_ptr_q;
      gcnt_d     = gcnt_q;
      scnt_d     = scnt_q;
      overflow_d = overflow_q;
      grant_d    = '0;

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d = ST_CLEAR;
            end
         end

         ST_CLEAR: begin
            pending_d  = req;
            gcnt_d     = '0;
            overflow_d = 1'b0;
            state_d    = ST_EVAL;
         end

         ST_EVAL: begin
            if (eff == '0) begin
               scnt_d  = SETTLE_LOAD;
               state_d = ST_SETTLE;
            end else if (grants_left) begin
               grant_d   = winner_oh;
               pending_d = eff & ~winner_oh;
               rr_ptr_d  = (winner == PTR_LAST) ? '0 : winner + 1'b1;
               gcnt_d    = gcnt_q + 1'b1;
            end else begin
               // Grant budget spent: drop everything still owed and wind down.
               overflow_d = 1'b1;
               pending_d  = '0;
               scnt_d     = SETTLE_LOAD;
               state_d    = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if ((req != '0) && grants_left) begin
               pending_d = req;
               state_d   = ST_EVAL;
            end else begin
               // A request with no budget left is dropped, but it must not
               // keep the frame alive, so the countdown still runs.
               if (req != '0) begin
                  overflow_d = 1'b1;
               end
               if (scnt_q <= SCNT_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  scnt_d = scnt_q - 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs decoded from the next state so each flop shows the state
      // it belongs to in the same cycle as the state register.
      fault_pulse_d = |grant_d;
      logic_reset_d = (state_d == ST_CLEAR);
      busy_d        = (state_d != ST_IDLE);
      frame_done_d  = (state_d == ST_DONE);
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pending_q     <= '0;
         rr_ptr_q      <= '0;
         gcnt_q        <= '0;
         scnt_q        <= '0;
         overflow_q    <= 1'b0;
         grant_q       <= '0;
         fault_pulse_q <= 1'b0;
         logic_reset_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         rr_ptr_q      <= rr_ptr_d;
         gcnt_q        <= gcnt_d;
         scnt_q        <= scnt_d;
         overflow_q    <= overflow_d;
         grant_q       <= grant_d;
         fault_pulse_q <= fault_pulse_d;
         logic_reset_q <= logic_reset_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign logic_reset = logic_reset_q;
   assign fault_pulse = fault_pulse_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_gate_fault_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gate_fault_frame_scheduler
//
// Directed frames with literal expectations, followed by randomized frames.
// A behavioural frame model runs alongside the DUT. Its outputs are compared
// with the DUT outputs on every cycle after the first reset.
// ---------------------------------------------------------------------------
module tb_gate_fault_frame_scheduler;

   localparam int N      = 4;
   localparam int SETTLE = 2;
   localparam int MAXG   = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         frame_start;
   logic [N-1:0] req;
   logic         logic_reset;
   logic         fault_pulse;
   logic [N-1:0] grant;
   logic         busy;
   logic         frame_done;
   logic         overflow;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   gate_fault_frame_scheduler #(
      .REQ_COUNT    (N),
      .SETTLE_CYCLES(SETTLE),
      .MAX_GRANTS   (MAXG)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .req        (req),
      .logic_reset(logic_reset),
      .fault_pulse(fault_pulse),
      .grant      (grant),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: frame phase, owed requests, rotation pointer,
   // grants used this frame, quiet-cycle countdown. Values held here are
   // what the outputs must show during the current cycle.
   // ------------------------------------------------------------------
   localparam int P_IDLE   = 0;
   localparam int P_CLEAR  = 1;
   localparam int P_EVAL   = 2;
   localparam int P_SETTLE = 3;
   localparam int P_DONE   = 4;

   int           m_ph    = P_IDLE;
   int           m_owed  = 0;
   int           m_ptr   = 0;
   int           m_used  = 0;
   int           m_quiet = 0;
   bit           m_ovf   = 1'b0;
   int           m_grant = 0;

   // Nearest requester at or after start, going round the ring.
   function automatic int pick(input int eff, input int start);
      for (int k = 0; k < N; k++) begin
         if (((eff >> ((start + k) % N)) & 1) != 0) begin
            return (start + k) % N;
         end
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int r;
      int eff;
      int w;
      int ng;
      r  = int'(req);
      ng = 0;
      if (reset) begin
         m_ph    = P_IDLE;
         m_owed  = 0;
         m_ptr   = 0;
         m_used  = 0;
         m_quiet = 0;
         m_ovf   = 1'b0;
      end else begin
         case (m_ph)
            P_IDLE: if (frame_start) m_ph = P_CLEAR;
            P_CLEAR: begin
               m_owed = r;
               m_used = 0;
               m_ovf  = 1'b0;
               m_ph   = P_EVAL;
            end
            P_EVAL: begin
               eff = m_owed | r;
               if (eff == 0) begin
                  m_ph    = P_SETTLE;
                  m_quiet = SETTLE;
               end else if (m_used < MAXG) begin
                  w      = pick(eff, m_ptr);
                  ng     = 1 << w;
                  m_owed = eff & ~ng;
                  m_ptr  = (w + 1) % N;
                  m_used = m_used + 1;
               end else begin
                  m_ovf   = 1'b1;
                  m_owed  = 0;
                  m_ph    = P_SETTLE;
                  m_quiet = SETTLE;
               end
            end
            P_SETTLE: begin
               if (r != 0 && m_used < MAXG) begin
                  m_owed = r;
                  m_ph   = P_EVAL;
               end else begin
                  if (r != 0) m_ovf = 1'b1;
                  m_quiet = m_quiet - 1;
                  if (m_quiet == 0) m_ph = P_DONE;
               end
            end
            default: m_ph = P_IDLE;
         endcase
      end
      m_grant = ng;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_logic_reset", 32'(logic_reset), 32'(m_ph == P_CLEAR));
         check("model_busy",        32'(busy),        32'(m_ph != P_IDLE));
         check("model_frame_done",  32'(frame_done),  32'(m_ph == P_DONE));
         check("model_grant",       32'(grant),       32'(m_grant));
         check("model_fault_pulse", 32'(fault_pulse), 32'(m_grant != 0));
         check("model_overflow",    32'(overflow),    32'(m_ovf));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change on the falling edge, outputs are
   // read on the falling edge after the rising edge that consumed them.
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("frame_done_within_budget", 32'(frame_done), 32'd1);
      step();
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({logic_reset, fault_pulse, grant, busy, frame_done, overflow});
   endfunction

   logic [N-1:0] rot [8];

   initial begin
      rot = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

      // Reset held with every input active.
      reset       = 1'b1;
      frame_start = 1'b1;
      req         = 4'hF;
      step();
      chk_en = 1'b1;
      check("reset_outs_c1", all_outs(), 32'd0);
      step();
      check("reset_outs_c2", all_outs(), 32'd0);
      step();
      check("reset_outs_c3", all_outs(), 32'd0);
      reset       = 1'b0;
      frame_start = 1'b0;
      req         = '0;
      step();
      check("idle_busy", 32'(busy), 32'd0);

      // Empty frame.
      frame_start = 1'b1;
      step();
      check("empty_logic_reset_c1", 32'(logic_reset), 32'd1);
      check("empty_busy_c1", 32'(busy), 32'd1);
      frame_start = 1'b0;
      step();
      check("empty_logic_reset_c2", 32'(logic_reset), 32'd0);
      check("empty_grant_c2", 32'(grant), 32'd0);
      step();
      step();
      check("empty_done_c4", 32'(frame_done), 32'd0);
      step();
      check("empty_done_c5", 32'(frame_done), 32'd1);
      check("empty_busy_c5", 32'(busy), 32'd1);
      step();
      check("empty_busy_after", 32'(busy), 32'd0);
      check("empty_done_after", 32'(frame_done), 32'd0);

      // Requests captured only in CLEAR.
      frame_start = 1'b1;
      step();
      req         = 4'b0101;
      frame_start = 1'b0;
      step();
      req = '0;
      step();
      check("clear_cap_grant1", 32'(grant), 32'h1);
      check("clear_cap_pulse1", 32'(fault_pulse), 32'd1);
      step();
      check("clear_cap_grant2", 32'(grant), 32'h4);
      check("clear_cap_pulse2", 32'(fault_pulse), 32'd1);
      step();
      check("clear_cap_grant3", 32'(grant), 32'h0);
      wait_done(10);

      // Full rotation from pointer 3, then grant budget exhaustion.
      frame_start = 1'b1;
      step();
      req         = 4'hF;
      frame_start = 1'b0;
      step();
      check("rot_no_grant_first_eval", 32'(grant), 32'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("rot_grant_%0d", k), 32'(grant), 32'(rot[k]));
         check($sformatf("rot_ovf_%0d", k), 32'(overflow), 32'd0);
      end
      step();
      check("budget_grant_off", 32'(grant), 32'd0);
      check("budget_overflow_set", 32'(overflow), 32'd1);
      step();
      check("budget_overflow_hold", 32'(overflow), 32'd1);
      step();
      check("budget_frame_done", 32'(frame_done), 32'd1);
      check("budget_overflow_done", 32'(overflow), 32'd1);
      req = '0;
      step();
      check("budget_overflow_idle", 32'(overflow), 32'd1);
      check("budget_busy_idle", 32'(busy), 32'd0);

      // Request arriving in the first quiet cycle reopens arbitration.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      check("reopen_overflow_cleared", 32'(overflow), 32'd0);
      step();
      req = 4'b0010;
      step();
      req = '0;
      step();
      check("reopen_grant", 32'(grant), 32'h2);
      step();
      check("reopen_settle1", 32'(frame_done), 32'd0);
      step();
      check("reopen_settle2", 32'(frame_done), 32'd0);
      step();
      check("reopen_done", 32'(frame_done), 32'd1);
      step();

      // Reset during an active grant, then pointer restart at 0.
      frame_start = 1'b1;
      step();
      req         = 4'hF;
      frame_start = 1'b0;
      step();
      step();
      check("midreset_grant_before", 32'(grant), 32'h4);
      reset = 1'b1;
      step();
      check("midreset_outs", all_outs(), 32'd0);
      reset = 1'b0;
      req   = '0;
      step();
      frame_start = 1'b1;
      step();
      req         = 4'hF;
      frame_start = 1'b0;
      step();
      step();
      check("midreset_ptr_zero", 32'(grant), 32'h1);
      req = '0;
      wait_done(20);

      // Randomized traffic, checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         frame_start = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = N'($urandom);
            2:       req = N'(1 << $urandom_range(0, N - 1));
            default: req = req;
         endcase
         step();
      end

      reset       = 1'b0;
      frame_start = 1'b0;
      req         = '0;
      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
